// File: rtl/bus_responder_pkg.sv
// Shared types and constants for the bus_responder register-bank target.
//   state_t : responder FSM states (IDLE, WAIT, RESP)
//   CNT_W   : width of the wait-state counter
//   req_t   : captured request (write flag, address, write data) at the
//             default address/data widths
package bus_responder_pkg;

    localparam int PKG_ADDR_W      = 4;
    localparam int PKG_DATA_W      = 32;
    localparam int PKG_NUM_REGS    = 12;
    localparam int PKG_WAIT_CYCLES = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/bus_responder.sv
// bus_responder: single-outstanding register-bank responder.
// Accepts one read/write request, inserts WAIT_CYCLES wait states, then
// presents a registered response held until the consumer accepts it.
//
// Parameters: ADDR_W, DATA_W, NUM_REGS (<= 2**ADDR_W), WAIT_CYCLES (0..15)
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req_valid/ready : request handshake (ready only in IDLE)
//   req_write       : 1 = write, 0 = read
//   req_addr        : register address
//   req_wdata       : write data
//   rsp_valid/ready : response handshake
//   rsp_rdata       : read data (zero for writes and out-of-range reads)
//   rsp_err         : access error
// Build option: BUS_RESPONDER_ERR_EN -- when defined, out-of-range accesses
// report rsp_err=1; otherwise rsp_err is tied to 0.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int ADDR_W      = PKG_ADDR_W,
    parameter int DATA_W      = PKG_DATA_W,
    parameter int NUM_REGS    = PKG_NUM_REGS,
    parameter int WAIT_CYCLES = PKG_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [ADDR_W:0]  NUM_REGS_X = (ADDR_W+1)'(NUM_REGS);
    // Terminal count of the wait counter; unused when WAIT_CYCLES is 0.
    localparam logic [CNT_W-1:0] WAIT_LAST  =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t             state_q;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    logic               req_write_p0;
    logic [ADDR_W-1:0]  req_addr_p0;
    logic [DATA_W-1:0]  req_wdata_p0;

    logic               req_hs;
    logic               rsp_hs;
    logic               enter_resp;
    logic               cmd_write;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [DATA_W-1:0]  cmd_wdata;
    logic               cmd_in_range;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NUM_REGS_X);
    endfunction

    assign req_hs     = req_valid && req_ready;
    assign rsp_hs     = rsp_valid && rsp_ready;
    assign enter_resp = (state_nxt == RESP) && (state_q != RESP);

    // With zero wait states the response is built on the acceptance edge,
    // before the latch holds the request, so take it straight from the bus.
    always_comb begin
        if (state_q == IDLE) begin
            cmd_write = req_write;
            cmd_addr  = req_addr;
            cmd_wdata = req_wdata;
        end else begin
            cmd_write = req_write_p0;
            cmd_addr  = req_addr_p0;
            cmd_wdata = req_wdata_p0;
        end
        cmd_in_range = addr_in_range(cmd_addr);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if (req_hs) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT: if (cnt_q == WAIT_LAST) state_nxt = RESP;
            RESP: if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: handshake flags depend on the state register only
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  cnt_q <= '0;
        else if (req_hs)          cnt_q <= '0;
        else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
    end

    // Stage p0: request capture (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (req_hs) begin
            req_write_p0 <= req_write;
            req_addr_p0  <= req_addr;
            req_wdata_p0 <= req_wdata;
        end
    end

    // Stage p1: register commit and response load, once per transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            rsp_rdata <= '0;
        end else if (enter_resp) begin
            if (cmd_write && cmd_in_range) regs[cmd_addr] <= cmd_wdata;
            if (!cmd_write && cmd_in_range) rsp_rdata <= regs[cmd_addr];
            else                            rsp_rdata <= '0;
        end
    end

`ifdef BUS_RESPONDER_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             rsp_err <= 1'b0;
        else if (enter_resp) rsp_err <= !cmd_in_range;
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_responder.sv
// Directed testbench for bus_responder: a default-parameter instance
// (WAIT_CYCLES=2) and a zero-wait instance share the request/response
// inputs; a select flag chooses whose outputs the transaction task observes.
module tb_bus_responder;

`ifdef BUS_RESPONDER_ERR_EN
    localparam logic ERR_OOR = 1'b1;
`else
    localparam logic ERR_OOR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [3:0]  req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;

    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic [31:0] rsp_rdata_a;
    logic        req_ready_z, rsp_valid_z, rsp_err_z;
    logic [31:0] rsp_rdata_z;

    bit          sel = 1'b0;
    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_a), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    bus_responder #(.WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_z), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
    );

    always_comb begin
        o_ready = sel ? req_ready_z : req_ready_a;
        o_valid = sel ? rsp_valid_z : rsp_valid_a;
        o_err   = sel ? rsp_err_z   : rsp_err_a;
        o_rdata = sel ? rsp_rdata_z : rsp_rdata_a;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction. lat counts cycles from the acceptance cycle up to and
    // including the first cycle rsp_valid is seen. The response is then held
    // for 'hold' cycles (optionally poking a stray write meant to be
    // ignored) before being accepted.
    task automatic xact(input bit wr, input logic [3:0] a, input logic [31:0] wd,
                        input int hold, input bit poke,
                        output logic [31:0] rd, output logic er, output int lat);
        int guard;
        guard = 0;
        rd = '0; er = 1'b0; lat = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        while (!o_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            check("req_ready_timeout", 64'(o_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (o_valid) break;
            lat++;
            if (lat > 20) begin
                check("rsp_valid_timeout", 64'(o_valid), 64'd1);
                return;
            end
        end
        rd = o_rdata;
        er = o_err;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd3;
                req_wdata = 32'h1234_5678;
            end
            @(negedge clk);
            check("bp_valid", 64'(o_valid), 64'd1);
            check("bp_rdata", 64'(o_rdata), 64'(rd));
            check("bp_req_ready", 64'(o_ready), 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("post_rsp_valid", 64'(o_valid), 64'd0);
        check("post_req_ready", 64'(o_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          cyc;
        int          nrsp;

        // Reset state of both instances
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready_a), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid_a), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata_a), 64'd0);
        check("rst_rsp_err",   64'(rsp_err_a),   64'd0);
        check("rst_w0_ready",  64'(req_ready_z), 64'd1);
        check("rst_w0_valid",  64'(rsp_valid_z), 64'd0);
        rst = 1'b0;

        // Write then read, two wait states: 3-cycle latency
        xact(1'b1, 4'd3, 32'hDEAD_BEEF, 0, 1'b0, rd, er, lat);
        check("wr3_lat",   64'(lat), 64'd3);
        check("wr3_err",   64'(er),  64'd0);
        check("wr3_rdata", 64'(rd),  64'd0);
        xact(1'b0, 4'd3, 32'h0, 0, 1'b0, rd, er, lat);
        check("rd3_lat",   64'(lat), 64'd3);
        check("rd3_rdata", 64'(rd),  64'hDEAD_BEEF);
        check("rd3_err",   64'(er),  64'd0);

        // Out-of-range write/read at 13
        xact(1'b1, 4'd13, 32'h1, 0, 1'b0, rd, er, lat);
        check("wr13_err",   64'(er),  64'(ERR_OOR));
        check("wr13_lat",   64'(lat), 64'd3);
        xact(1'b0, 4'd13, 32'h0, 0, 1'b0, rd, er, lat);
        check("rd13_err",   64'(er),  64'(ERR_OOR));
        check("rd13_rdata", 64'(rd),  64'd0);

        // Boundary addresses: 11 is the last register, 12 the first hole
        xact(1'b1, 4'd11, 32'hA5A5_0F0F, 0, 1'b0, rd, er, lat);
        check("wr11_err", 64'(er), 64'd0);
        xact(1'b0, 4'd11, 32'h0, 0, 1'b0, rd, er, lat);
        check("rd11_rdata", 64'(rd), 64'hA5A5_0F0F);
        xact(1'b1, 4'd12, 32'hFFFF_FFFF, 0, 1'b0, rd, er, lat);
        check("wr12_err", 64'(er), 64'(ERR_OOR));
        xact(1'b0, 4'd12, 32'h0, 0, 1'b0, rd, er, lat);
        check("rd12_err",   64'(er), 64'(ERR_OOR));
        check("rd12_rdata", 64'(rd), 64'd0);

        // Backpressure: 5 held cycles with a stray write on the bus
        xact(1'b0, 4'd3, 32'h0, 5, 1'b1, rd, er, lat);
        check("bp_rd3_rdata", 64'(rd), 64'hDEAD_BEEF);
        xact(1'b0, 4'd3, 32'h0, 0, 1'b0, rd, er, lat);
        check("stray_ignored", 64'(rd), 64'hDEAD_BEEF);

        // Reset during WAIT of a write to address 2
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd2; req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(rsp_valid_a), 64'd0);
        check("mid_rst_ready", 64'(req_ready_a), 64'd1);
        repeat (2) @(negedge clk);
        check("mid_rst_valid_hold", 64'(rsp_valid_a), 64'd0);
        rst = 1'b0;
        xact(1'b0, 4'd2, 32'h0, 0, 1'b0, rd, er, lat);
        check("rd2_after_rst", 64'(rd), 64'd0);
        xact(1'b0, 4'd3, 32'h0, 0, 1'b0, rd, er, lat);
        check("rd3_after_rst", 64'(rd), 64'd0);

        // Zero-wait instance
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b1;
        xact(1'b1, 4'd5, 32'h0000_0011, 0, 1'b0, rd, er, lat);
        check("w0_wr_lat", 64'(lat), 64'd1);
        xact(1'b0, 4'd5, 32'h0, 0, 1'b0, rd, er, lat);
        check("w0_rd_lat",   64'(lat), 64'd1);
        check("w0_rd_rdata", 64'(rd),  64'h11);

        // Back-to-back reads with no backpressure: 4 transactions, 8 cycles
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
        rsp_ready = 1'b1;
        cyc = 0;
        nrsp = 0;
        while (nrsp < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid_z) begin
                nrsp++;
                check("w0_stream_rdata", 64'(rsp_rdata_z), 64'h11);
            end
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("w0_stream_count",  64'(nrsp),    64'd4);
        check("w0_stream_cycles", 64'(cyc + 1), 64'd8);
        check("w0_stream_idle",   64'(req_ready_z), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
